// File: rtl/io_input_debounce.sv
// Input conditioning for the board slide switches and pushbuttons feeding the LSU switch read port.
// Each channel gets a synchronizer chain and a stable-time debouncer; the result is packed into one 32-bit word.
module io_input_debounce #(
    parameter int NUM_SW          = 18,
    parameter int NUM_KEY         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    // Keeps the key port at least one bit wide when a board has no pushbuttons.
    localparam int KEY_PORT_W     = (NUM_KEY > 0) ? NUM_KEY : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_SW-1:0]     i_sw_raw,
    input  logic [KEY_PORT_W-1:0] i_key_n_raw,
    output logic [31:0]           o_io_sw,
    output logic                  o_sw_changed
);

    localparam int NUM_CH            = NUM_SW + NUM_KEY;
    localparam int CNT_W             = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] raw_ch;
    logic [NUM_CH-1:0] stb;
    logic [NUM_CH-1:0] toggle;

    assign raw_ch[NUM_SW-1:0] = i_sw_raw;

    if (NUM_KEY > 0) begin : g_key_in
        assign raw_ch[NUM_CH-1:NUM_SW] = i_key_n_raw[NUM_KEY-1:0];
    end else begin : g_no_key
        logic unused_key;
        assign unused_key = ^i_key_n_raw;
    end

    // Switches occupy the low channel indices, keys the high ones.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic IS_KEY = 1'(c >= NUM_SW);

        logic [SYNC_STAGES-1:0] sync_ff;
        logic [CNT_W-1:0]       cnt;
        logic                   stb_q;
        logic                   sync_lvl;

        // Keys idle high at the pin, so their chain resets to the released level.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                sync_ff <= {SYNC_STAGES{IS_KEY}};
            end else begin
                sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw_ch[c]};
            end
        end

        assign sync_lvl = sync_ff[SYNC_STAGES-1] ^ IS_KEY;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                cnt   <= '0;
                stb_q <= 1'b0;
            end else if (sync_lvl == stb_q) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stb_q <= sync_lvl;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign toggle[c] = (sync_lvl != stb_q) && (cnt == CNT_MAX);
        assign stb[c]    = stb_q;
    end

    // One pulse per edge regardless of how many channels settled on it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sw_changed <= 1'b0;
        end else begin
            o_sw_changed <= |toggle;
        end
    end

    assign o_io_sw[NUM_SW-1:0] = stb[NUM_SW-1:0];

    if (NUM_SW < 24) begin : g_sw_pad
        assign o_io_sw[23:NUM_SW] = '0;
    end

    if (NUM_KEY > 0) begin : g_key_out
        assign o_io_sw[24 +: NUM_KEY] = stb[NUM_SW +: NUM_KEY];
    end

    if (NUM_KEY < 8) begin : g_key_pad
        assign o_io_sw[31:24+NUM_KEY] = '0;
    end

endmodule

// File: tb/tb_io_input_debounce.sv
// Scoreboard bench for io_input_debounce with a short debounce window.
// Stimulus pushes expected change events; a monitor pops them whenever o_sw_changed fires.
module tb_io_input_debounce;

    typedef struct {
        logic [31:0] word;
        int          cycle;
    } exp_t;

    logic        clk;
    logic        i_reset;
    logic [17:0] sw_raw;
    logic [3:0]  key_n_raw;
    logic [31:0] io_sw;
    logic        sw_changed;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;
    int   k;

    io_input_debounce #(
        .NUM_SW          (18),
        .NUM_KEY         (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_sw_raw     (sw_raw),
        .i_key_n_raw  (key_n_raw),
        .o_io_sw      (io_sw),
        .o_sw_changed (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every pulse must match the next queued event, on the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missed_pulse: no o_sw_changed at cycle %0d (word %h expected)", e.cycle, e.word);
        end
        if (sw_changed === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: o_sw_changed=1 at cycle %0d, o_io_sw=%h, required no pulse", cyc, io_sw);
            end else begin
                e = exp_q.pop_front();
                if (io_sw !== e.word || cyc != e.cycle) begin
                    errors++;
                    $display("[TB] FAIL pulse_event: got word %h at cycle %0d, required word %h at cycle %0d",
                             io_sw, cyc, e.word, e.cycle);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [17:0] sw, input logic [3:0] key_n);
        sw_raw    = sw;
        key_n_raw = key_n;
    endtask

    task automatic expectPulse(input logic [31:0] word, input int cycle);
        exp_t e;
        e.word  = word;
        e.cycle = cycle;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp_word, input logic exp_chg);
        checks++;
        if (io_sw !== exp_word || sw_changed !== exp_chg) begin
            errors++;
            $display("[TB] FAIL %s: o_io_sw=%h o_sw_changed=%b, required %h / %b",
                     name, io_sw, sw_changed, exp_word, exp_chg);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        i_reset = 1'b0;
        applyStimulus(18'h3FFFF, 4'h0);
        #1 i_reset = 1'b1;
        #1 checkOutput("reset_async", 32'h0, 1'b0);
        waitCycles(3);
        checkOutput("reset_hold", 32'h0, 1'b0);

        // Release with all switches up and all keys pressed.
        i_reset = 1'b0;
        k = cyc;
        expectPulse(32'h0F03_FFFF, k + 6);
        waitCycles(5);
        checkOutput("release_e5", 32'h0, 1'b0);
        waitCycles(1);
        checkOutput("release_e6", 32'h0F03_FFFF, 1'b1);
        waitCycles(1);
        checkOutput("release_e7", 32'h0F03_FFFF, 1'b0);

        applyStimulus(18'h0, 4'hF);
        expectPulse(32'h0, cyc + 6);
        waitCycles(8);
        checkOutput("clear1", 32'h0, 1'b0);

        // Latency on SW0.
        applyStimulus(18'h1, 4'hF);
        k = cyc;
        expectPulse(32'h1, k + 6);
        waitCycles(5);
        checkOutput("latency_e5", 32'h0, 1'b0);
        waitCycles(1);
        checkOutput("latency_e6", 32'h1, 1'b1);
        waitCycles(1);
        checkOutput("latency_e7", 32'h1, 1'b0);

        applyStimulus(18'h0, 4'hF);
        expectPulse(32'h0, cyc + 6);
        waitCycles(8);

        // Three-cycle glitch on SW5 is the longest that must be rejected.
        applyStimulus(18'h20, 4'hF);
        waitCycles(3);
        applyStimulus(18'h0, 4'hF);
        waitCycles(4);
        checkOutput("glitch_mid", 32'h0, 1'b0);
        waitCycles(6);
        checkOutput("glitch_end", 32'h0, 1'b0);

        // Four cycles is just long enough to rise and later fall.
        applyStimulus(18'h20, 4'hF);
        k = cyc;
        expectPulse(32'h20, k + 6);
        expectPulse(32'h0, k + 10);
        waitCycles(4);
        applyStimulus(18'h0, 4'hF);
        waitCycles(5);
        checkOutput("pulse4_hold", 32'h20, 1'b0);
        waitCycles(3);
        checkOutput("pulse4_end", 32'h0, 1'b0);

        // KEY0 bounces before settling pressed.
        applyStimulus(18'h0, 4'hE);
        waitCycles(2);
        applyStimulus(18'h0, 4'hF);
        waitCycles(2);
        applyStimulus(18'h0, 4'hE);
        waitCycles(2);
        applyStimulus(18'h0, 4'hF);
        waitCycles(2);
        applyStimulus(18'h0, 4'hE);
        k = cyc;
        expectPulse(32'h0100_0000, k + 6);
        waitCycles(5);
        checkOutput("bounce_e5", 32'h0, 1'b0);
        waitCycles(1);
        checkOutput("bounce_e6", 32'h0100_0000, 1'b1);
        waitCycles(3);

        // SW17 and KEY3 change together.
        applyStimulus(18'h20000, 4'h6);
        k = cyc;
        expectPulse(32'h0902_0000, k + 6);
        waitCycles(5);
        checkOutput("simul_e5", 32'h0100_0000, 1'b0);
        waitCycles(1);
        checkOutput("simul_e6", 32'h0902_0000, 1'b1);
        waitCycles(1);
        checkOutput("simul_e7", 32'h0902_0000, 1'b0);
        waitCycles(1);

        // Asynchronous clear between clock edges.
        #2 i_reset = 1'b1;
        #1 checkOutput("async_clear", 32'h0, 1'b0);
        applyStimulus(18'h0, 4'hF);
        @(negedge clk);
        i_reset = 1'b0;
        waitCycles(8);
        checkOutput("post_reset_idle", 32'h0, 1'b0);

        // Reset in the middle of a count must restart the full delay.
        applyStimulus(18'h4, 4'hF);
        waitCycles(3);
        i_reset = 1'b1;
        #1 checkOutput("midreset_async", 32'h0, 1'b0);
        @(negedge clk);
        i_reset = 1'b0;
        k = cyc;
        expectPulse(32'h4, k + 6);
        waitCycles(5);
        checkOutput("midreset_e5", 32'h0, 1'b0);
        waitCycles(1);
        checkOutput("midreset_e6", 32'h4, 1'b1);
        waitCycles(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL queue_drain: %0d events pending, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
